imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, handshaked, parametrised successor to the combinational immediate_generator. It decodes the immediate from a 32-bit RISC-V instruction for XLEN=32 or 64, and adds CSR zimm and shift-amount formats. It sits between the decode and execute pipeline registers as an elastic stage, with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush. A side-band tag (PC/rd/ROB id) travels alongside the data.

Parameters:
XLEN, 32, output width; legal values 32 or 64, any other value triggers a $fatal at elaboration.
TAG_W, 8, width of the side-band tag carried with each instruction.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush; discards all held and incoming entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept; registered, depends only on internal state
in_instr  input  32  instruction word
in_imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), 110 SH (shamt), 111 reserved
in_tag  input  TAG_W  side-band tag
out_valid  output  1  immediate valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  decoded immediate
out_illegal  output  1  in_imm_src was 111
out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_imm=0, out_illegal=0, out_tag=0, skid empty, in_ready=1.
- Transfer in: accepted when in_valid && in_ready at the clock edge. Transfer out: when out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N, provided the output register was empty or draining.
- Immediate rules (sign-extend to XLEN from instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to 64 bits when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extended instr[19:15].
  - SH: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 111: out_imm=0, out_illegal=1. The entry is still passed through; it is not dropped.
- Storage: the output register plus one skid entry (2 entries total).
- Accept while the output is empty or draining (out_ready=1): the new entry loads the output register directly.
- Accept while out_valid=1 and out_ready=0: the entry goes to the skid. in_ready goes to 0 from the next cycle.
- Output transfer while the skid is full: the skid moves into the output register and in_ready returns to 1 in the next cycle. Throughput is 1 per cycle with no bubbles.
- Ordering is strictly FIFO. Tag, immediate and illegal flag of an entry never separate.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- flush=1 at an edge: out_valid=0, skid emptied, in_ready=1 next cycle. An in_valid presented in the same cycle is discarded, even if in_ready=1. flush takes priority over all transfers. out_imm/out_tag keep their last values; they are don't-care while out_valid=0.
- rst_n asserted mid-transfer: immediate return to the reset state; all in-flight entries are lost.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Test Plan:
- XLEN=64, I, instr 0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF one cycle later. U, instr 0x800000B7 -> 0xFFFFFFFF80000000. XLEN=32 U, same instr -> 0x80000000.
- Format sweep at XLEN=32 with out_ready=1, back-to-back, tags 1..7:
  - B 0xF8208EF3 -> 0xFFFFFF9C
  - J 0xFCDFF0EF -> 0xFFFFFFCC
  - S 0xFE112E23 -> 0xFFFFFFFC
  - Z instr[19:15]=5'h1F -> 0x0000001F
  - SH 0x03F09093 -> 0x1F (XLEN=64: 0x3F)
  - src 111 -> imm 0, out_illegal=1
  - Requirement: one output per cycle, tags in order.
- Backpressure: hold out_ready=0, drive 3 valid instrs with tags A, B, C. A and B are accepted; in_ready=0 on the cycle after B's acceptance; C is stalled. Release out_ready -> outputs A, B, C in order, none lost or duplicated, out_* stable while stalled.
- Flush with a full skid (A in the output register, B in the skid) and C on the input, all in the same cycle -> next cycle out_valid=0, in_ready=1, C never appears. The next accepted D emerges alone.
- Async reset mid-stream: assert rst_n=0 between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for a clock. After release, new traffic decodes correctly.
- Random valid/ready toggling: 10,000 random instructions against a reference model -> every immediate/tag matches, in order.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Elastic pipeline stage decoding the RISC-V immediate (XLEN 32/64) with a
// valid/ready handshake, a one-entry skid behind the output register, and flush.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    SRC_I   = 3'd0,
    SRC_S   = 3'd1,
    SRC_B   = 3'd2,
    SRC_U   = 3'd3,
    SRC_J   = 3'd4,
    SRC_Z   = 3'd5,
    SRC_SH  = 3'd6,
    SRC_RSV = 3'd7
  } imm_src_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] raw_imm;
  logic        raw_illegal;
  entry_t      in_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic accept;
  logic out_free;

  // Decode to a 32-bit value whose bit 31 already carries the extension sign.
  always_comb begin
    raw_imm     = 32'd0;
    raw_illegal = 1'b0;
    case (imm_src_e'(in_imm_src))
      SRC_I:  raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      SRC_S:  raw_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SRC_B:  raw_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      SRC_U:  raw_imm = {in_instr[31:12], 12'd0};
      SRC_J:  raw_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      SRC_Z:  raw_imm = {27'd0, in_instr[19:15]};
      SRC_SH: raw_imm = (XLEN == 64) ? {26'd0, in_instr[25:20]}
                                     : {27'd0, in_instr[24:20]};
      default: begin
        raw_imm     = 32'd0;
        raw_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_entry.imm     = XLEN'($signed(raw_imm));
    in_entry.illegal = raw_illegal;
    in_entry.tag     = in_tag;
  end

  assign accept   = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  // Next-state: flush wins; a freed output takes the skid first to keep FIFO order.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        ir32, ov32, il32, ir64, ov64, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tg32, tg64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_illegal(il32), .out_tag(tg32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_illegal(il64), .out_tag(tg64)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [7:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [7:0]  tag;
  } ent_t;

  vec_t vt[9];
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] ins,
                       input logic [7:0] tag);
    in_valid   = v;
    in_imm_src = src;
    in_instr   = ins;
    in_tag     = tag;
  endtask

  task automatic chk_hs(input string name, input logic ov, input logic ir);
    chk({name, ".out_valid32"}, 64'(ov32), 64'(ov));
    chk({name, ".out_valid64"}, 64'(ov64), 64'(ov));
    chk({name, ".in_ready32"},  64'(ir32), 64'(ir));
    chk({name, ".in_ready64"},  64'(ir64), 64'(ir));
  endtask

  task automatic chk_data(input string name, input logic [7:0] tag, input logic [31:0] e32,
                          input logic [63:0] e64, input logic ill);
    chk({name, ".tag32"}, 64'(tg32), 64'(tag));
    chk({name, ".tag64"}, 64'(tg64), 64'(tag));
    chk({name, ".imm32"}, 64'(imm32), 64'(e32));
    chk({name, ".imm64"}, imm64, e64);
    chk({name, ".ill32"}, 64'(il32), 64'(ill));
    chk({name, ".ill64"}, 64'(il64), 64'(ill));
  endtask

  function automatic logic [63:0] sext(input logic [63:0] x, input int n);
    if (x[n-1]) return x - (64'd1 << n);
    return x;
  endfunction

  // Immediate assembled field-by-field with shifts and masks, then narrowed.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] src,
                                        input int xlen);
    logic [63:0] w, v;
    w = 64'(ins);
    case (src)
      3'd0: v = sext(w >> 20, 12);
      3'd1: v = sext(((w >> 25) << 5) | ((w >> 7) & 64'h1f), 12);
      3'd2: v = sext((((w >> 31) & 64'h1) << 12) | (((w >> 7) & 64'h1) << 11) |
                     (((w >> 25) & 64'h3f) << 5) | (((w >> 8) & 64'hf) << 1), 13);
      3'd3: v = sext(w & 64'hFFFF_F000, 32);
      3'd4: v = sext((((w >> 31) & 64'h1) << 20) | (((w >> 12) & 64'hff) << 12) |
                     (((w >> 20) & 64'h1) << 11) | (((w >> 21) & 64'h3ff) << 1), 21);
      3'd5: v = (w >> 15) & 64'h1f;
      3'd6: v = (xlen == 64) ? ((w >> 20) & 64'h3f) : ((w >> 20) & 64'h1f);
      default: v = 64'd0;
    endcase
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  initial begin
    vt[0] = '{3'd0, 32'hFFF00093, 8'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vt[1] = '{3'd3, 32'h800000B7, 8'd2, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
    vt[2] = '{3'd2, 32'hF8208EF3, 8'd3, 32'hFFFFFF9C, 64'hFFFFFFFF_FFFFFF9C, 1'b0};
    vt[3] = '{3'd4, 32'hFCDFF0EF, 8'd4, 32'hFFFFFFCC, 64'hFFFFFFFF_FFFFFFCC, 1'b0};
    vt[4] = '{3'd1, 32'hFE112E23, 8'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vt[5] = '{3'd5, 32'hFFFFF073, 8'd6, 32'h0000001F, 64'h00000000_0000001F, 1'b0};
    vt[6] = '{3'd6, 32'h03F09093, 8'd7, 32'h0000001F, 64'h00000000_0000003F, 1'b0};
    vt[7] = '{3'd7, 32'hFFFFFFFF, 8'd8, 32'h00000000, 64'h00000000_00000000, 1'b1};
    vt[8] = '{3'd0, 32'h7FF00093, 8'd9, 32'h000007FF, 64'h00000000_000007FF, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    #12;
    chk_hs("reset", 1'b0, 1'b1);
    chk_data("reset", 8'd0, 32'd0, 64'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Back-to-back format sweep, one result per cycle in tag order.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vt[i].src, vt[i].instr, vt[i].tag);
      chk("sweep.in_ready", 64'(ir32), 64'd1);
      tick();
      chk_hs($sformatf("sweep%0d", i), 1'b1, 1'b1);
      chk_data($sformatf("sweep%0d", i), vt[i].tag, vt[i].e32, vt[i].e64, vt[i].ill);
    end
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    tick();
    chk_hs("sweep.drain", 1'b0, 1'b1);

    // Backpressure: A to output, B to skid, C stalled.
    out_ready = 1'b0;
    drive(1'b1, vt[0].src, vt[0].instr, 8'hA0);
    tick();
    chk_hs("bp.A", 1'b1, 1'b1);
    drive(1'b1, vt[2].src, vt[2].instr, 8'hB0);
    tick();
    chk_hs("bp.B", 1'b1, 1'b0);
    chk_data("bp.B_holdA", 8'hA0, vt[0].e32, vt[0].e64, 1'b0);
    drive(1'b1, vt[3].src, vt[3].instr, 8'hC0);
    tick();
    tick();
    chk_hs("bp.C_stall", 1'b1, 1'b0);
    chk_data("bp.C_stall_holdA", 8'hA0, vt[0].e32, vt[0].e64, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_hs("bp.outB", 1'b1, 1'b1);
    chk_data("bp.outB", 8'hB0, vt[2].e32, vt[2].e64, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    chk_hs("bp.outC", 1'b1, 1'b1);
    chk_data("bp.outC", 8'hC0, vt[3].e32, vt[3].e64, 1'b0);
    tick();
    chk_hs("bp.empty", 1'b0, 1'b1);

    // Flush with a full skid and C on the input.
    out_ready = 1'b0;
    drive(1'b1, vt[1].src, vt[1].instr, 8'hA1);
    tick();
    drive(1'b1, vt[4].src, vt[4].instr, 8'hB1);
    tick();
    chk_hs("fl.full", 1'b1, 1'b0);
    drive(1'b1, vt[5].src, vt[5].instr, 8'hC1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    chk_hs("fl.after", 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    chk_hs("fl.idle", 1'b0, 1'b1);
    drive(1'b1, vt[6].src, vt[6].instr, 8'hD1);
    tick();
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    chk_hs("fl.D", 1'b1, 1'b1);
    chk_data("fl.D", 8'hD1, vt[6].e32, vt[6].e64, 1'b0);
    tick();
    chk_hs("fl.D_alone", 1'b0, 1'b1);

    // Asynchronous reset between edges with a full stage.
    out_ready = 1'b0;
    drive(1'b1, vt[2].src, vt[2].instr, 8'hA2);
    tick();
    drive(1'b1, vt[3].src, vt[3].instr, 8'hB2);
    tick();
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_hs("arst.now", 1'b0, 1'b1);
    chk_data("arst.now", 8'd0, 32'd0, 64'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_hs("arst.idle", 1'b0, 1'b1);
    drive(1'b1, vt[4].src, vt[4].instr, 8'hE2);
    tick();
    drive(1'b0, 3'd0, 32'd0, 8'd0);
    chk_hs("arst.new", 1'b1, 1'b1);
    chk_data("arst.new", 8'hE2, vt[4].e32, vt[4].e64, 1'b0);
    tick();

    // Random traffic against an occupancy/FIFO model.
    begin
      int accepted = 0;
      int cyc = 0;
      logic prev_stall = 1'b0;
      logic [31:0] p_imm32;
      logic [63:0] p_imm64;
      logic [7:0]  p_tag;
      logic        p_ill;
      q.delete();
      while (accepted < 10000 && cyc < 60000) begin
        logic acc, fire;
        ent_t e;
        drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, 8'($urandom));
        out_ready = ($urandom_range(0, 9) < 7);
        flush = ($urandom_range(0, 63) == 0);
        chk_hs("rnd.hs", q.size() > 0, q.size() < 2);
        if (prev_stall) begin
          chk("rnd.stable.imm32", 64'(imm32), 64'(p_imm32));
          chk("rnd.stable.imm64", imm64, p_imm64);
          chk("rnd.stable.tag", 64'(tg32), 64'(p_tag));
          chk("rnd.stable.ill", 64'(il32), 64'(p_ill));
        end
        fire = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2);
        if (flush) begin
          q.delete();
        end else begin
          if (fire) begin
            e = q.pop_front();
            chk_data("rnd.out", e.tag, 32'(model(e.instr, e.src, 32)),
                     model(e.instr, e.src, 64), e.src == 3'd7);
          end
          if (acc) begin
            q.push_back('{in_instr, in_imm_src, in_tag});
            accepted++;
          end
        end
        prev_stall = ov32 && !out_ready && !flush;
        p_imm32 = imm32;
        p_imm64 = imm64;
        p_tag   = tg32;
        p_ill   = il32;
        tick();
        cyc++;
      end
      chk("rnd.budget", 64'(accepted >= 10000), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
